// File: rtl/uart_rx_frontend_pkg.sv
// Shared definitions for the loader's UART receive path: state encoding,
// default bit timing, loader frame markers and the 2-of-3 vote helper.
package uart_rx_frontend_pkg;

  // 11.0592 MHz / 115200 baud
  localparam int DEF_CLKS_PER_BIT = 96;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Byte markers the loader FSM looks for in the received stream
  localparam logic [7:0] LDR_SYNC        = 8'hFF;
  localparam logic [7:0] LDR_TYPE_MODEL  = 8'h01;
  localparam logic [7:0] LDR_TYPE_WEIGHT = 8'h02;
  localparam logic [7:0] LDR_TYPE_TENSOR = 8'h03;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte stream from the UART receiver to the loader FSM.
interface uart_rx_frontend_if;
  logic [7:0] RxData;
  logic       valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (output RxData, valid, frame_err, rx_busy);
  modport slave  (input  RxData, valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_sample_vote.sv
// Three-tap history of the synchronised line and a registered 2-of-3 vote,
// so a single-cycle spike near a bit centre cannot flip the sampled bit.
module uart_sample_vote
  import uart_rx_frontend_pkg::*;
(
  input  logic clk_11MHz,
  input  logic reset,
  input  logic rx_s,
  output logic vote
);

  logic [1:0] taps;

  // The vote seen in cycle t covers rx_s from cycles t-3, t-2 and t-1
  always_ff @(posedge clk_11MHz) begin
    if (reset) begin
      taps <= 2'b11;
      vote <= 1'b1;
    end else begin
      taps <= {taps[0], rx_s};
      vote <= maj3(taps[1], taps[0], rx_s);
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 serial byte receiver: synchroniser, bit timer and frame FSM that hands
// each good byte to the loader with a one-cycle valid strobe.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk_11MHz,
  input  logic                reset,
  input  logic                rx_pin,
  uart_rx_frontend_if.master  rx_if
);

  localparam int MID = CLKS_PER_BIT / 2 - 1;
  // The vote covering timer values MID-1..MID+1 is readable at MID+2
  localparam logic [CNT_WIDTH-1:0] START_DECIDE = CNT_WIDTH'(MID + 2);
  localparam logic [CNT_WIDTH-1:0] BIT_END      = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   vote;

  rx_state_t              state;
  logic [CNT_WIDTH-1:0]   timer;
  logic [CNT_WIDTH-1:0]   timer_inc;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic [7:0]             rxdata_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   busy_q;

  // NOTE: non-blocking, so each stage takes the previous stage's old value.
  always_ff @(posedge clk_11MHz) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_sample_vote u_vote (
    .clk_11MHz (clk_11MHz),
    .reset     (reset),
    .rx_s      (rx_s),
    .vote      (vote)
  );

  assign timer_inc = (&timer) ? timer : timer + CNT_WIDTH'(1);

  always_ff @(posedge clk_11MHz) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rxdata_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: strobes default low here; a later assignment in the case wins.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      timer       <= timer_inc;
      case (state)
        ST_IDLE: begin
          timer  <= '0;
          busy_q <= 1'b0;
          if (!rx_s) begin
            state  <= ST_START;
            busy_q <= 1'b1;
          end
        end
        ST_START: begin
          if (timer == START_DECIDE) begin
            timer   <= '0;
            bit_idx <= '0;
            if (vote) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (timer == BIT_END) begin
            timer   <= '0;
            shreg   <= {vote, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leaves the stop bit at its centre so a start edge right after it is seen
          if (timer == BIT_END) begin
            timer <= '0;
            if (vote) begin
              rxdata_q <= shreg;
              valid_q  <= 1'b1;
              state    <= ST_IDLE;
              busy_q   <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state       <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (!rx_s) begin
            timer <= '0;
          end else if (timer == BIT_END) begin
            timer  <= '0;
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.RxData    = rxdata_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = busy_q;

endmodule
